// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed shift/add multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SUB   = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/shift_add_multiplier_n_add_sub_ext.sv
// WIDTH+1-bit adder/subtractor on sign-extended operands; the extra bit
// keeps the last-step subtraction of the most negative multiplicand exact.
module add_sub_ext #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = sub ? ~{b[WIDTH-1], b} : {b[WIDTH-1], b};
  assign sum   = a_ext + b_ext + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/shift_add_multiplier_n.sv
// Signed WIDTH x WIDTH sequential multiplier: product lands in {Aval, Bval},
// with Busy while iterating and a one-cycle Done pulse in FIN.
//
// state | meaning
// IDLE  | wait for Run edge; ClearA_LoadB loads B from S
// ADD   | A += S for a set multiplier bit
// SUB   | A -= S for the set sign bit of the multiplier
// SHIFT | arithmetic shift of {X,A,B}, advance bit counter
// FIN   | product valid, Done pulse
module shift_add_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           run_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic           x_q;
  logic [WIDTH:0] sum;
  logic           start;

  assign start = Run & ~run_q;

  add_sub_ext #(.WIDTH(WIDTH)) u_add_sub (
    .a   (a_q),
    .b   (S),
    .sub (state == SUB),
    .sum (sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      run_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      run_q <= Run;
      case (state)
        IDLE: begin
          // Load has priority; a coincident Run edge is dropped.
          if (ClearA_LoadB) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= S;
          end else if (start) begin
            a_q   <= '0;
            x_q   <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= b_q[0] ? ADD : SHIFT;
          end
        end
        ADD, SUB: begin
          {x_q, a_q} <= sum;
          state      <= SHIFT;
        end
        SHIFT: begin
          {x_q, a_q, b_q} <= {x_q, x_q, a_q, b_q[WIDTH-1:1]};
          if (cnt == CNT_LAST) begin
            state <= FIN;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
            // b_q[1] becomes the next multiplier bit after this shift.
            if (b_q[1])
              state <= ((cnt + CNT_ONE) == CNT_LAST) ? SUB : ADD;
            else
              state <= SHIFT;
          end
        end
        FIN: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;

endmodule

// File: doc/shift_add_multiplier_n.md
# shift_add_multiplier_n

Parametrised signed (two's-complement) sequential multiplier with a counter-driven control FSM and integrated datapath. Replaces the fixed 8-bit unrolled controller: one loop state set serves any WIDTH, and it adds Busy/Done handshake, Run edge detection and consecutive-multiply chaining. Sits between switch/button inputs (S, Run, ClearA_LoadB) and the hex-display drivers (Aval, Bval, X).

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Run  in  1  level input; a 0->1 transition sampled on Clk starts a multiply
- ClearA_LoadB  in  1  synchronous, active-high; in IDLE: A<=0, X<=0, B<=S
- S  in  WIDTH  multiplicand; also the B load value
- Aval  out  WIDTH  upper product half (register A)
- Bval  out  WIDTH  lower product half / multiplier (register B)
- X  out  1  sign-extension bit of A
- Busy  out  1  high in ADD, SUB, SHIFT
- Done  out  1  one-cycle pulse, product valid

## Operation
- States: IDLE, ADD, SUB, SHIFT, FIN.
- Run edge: run_q registers Run; start = Run & ~run_q. Accepted only in IDLE.
- IDLE: ClearA_LoadB -> A=0, X=0, B=S. On start: A=0, X=0, cnt=0, B kept; next = (B[0] ? (WIDTH==1 impossible) ADD : SHIFT). Last-bit SUB rule below applies to cnt==WIDTH-1.
- ADD: {X,A} <= sext(A) + sext(S), WIDTH+1-bit sum; -> SHIFT.
- SUB (entered instead of ADD when cnt==WIDTH-1 and B[0]=1): {X,A} <= sext(A) + sext(~S) + 1; -> SHIFT.
- SHIFT: {X,A,B} <= arithmetic right shift by 1 (X replicated); cnt++. If cnt==WIDTH-1 -> FIN; else next by new B[0]: 1 -> ADD (or SUB if cnt+1==WIDTH-1), 0 -> SHIFT.
- FIN: Done=1 for exactly this cycle; -> IDLE. Product = signed {A,B}, 2*WIDTH bits; X == A[WIDTH-1].
- Chaining: a new start from IDLE reuses B (previous low half) as multiplier with current S; no reload needed.
- S must be stable while Busy; S changes mid-operation give undefined product (no checking).
- Arithmetic: no overflow possible; -2^(W-1) * -2^(W-1) = 2^(2W-2) must be exact.

## Timing
- Reset values: Aval=0, Bval=0, X=0, Busy=0, Done=0, state IDLE, cnt=0, run_q=0.
- Reset mid-operation: immediate return to reset values; no Done pulse.
- Latency: start edge (cycle t) -> FIN at cycle t + WIDTH + popcount(B) ; Done high that cycle; Busy low in FIN.
- Run held high across completion does not retrigger; release then re-press required.
- Run edge while Busy or FIN: ignored, not queued.
- ClearA_LoadB while Busy/FIN: ignored. ClearA_LoadB and start same cycle in IDLE: ClearA_LoadB wins, start dropped.
- Aval/Bval/X are register outputs; intermediate values visible while Busy.

## Structure
- Package mult_pkg: state enum typedef (logic [2:0]), MIN_WIDTH constant.
- cnt width $clog2(WIDTH).
- One sub-module: add_sub_ext (WIDTH+1-bit add/subtract, sext inputs, Sub control) instantiated once; FSM, counter, shift registers in top.

## Test plan
- WIDTH=8: S=0x03, ClearA_LoadB; S=0x07, Run pulse -> Done after 10 cycles, {A,B}=0x0015, X=0.
- WIDTH=8: B=0xFF, S=0xFF -> {A,B}=0x0001, X=0; B=0x80, S=0x80 -> 0x4000, latency 9.
- Chain: after 0x0015 result, S=0x02, Run pulse -> {A,B}=0x002A; Run held 40 cycles -> exactly one Done.
- Reset asserted at 4th Busy cycle -> outputs 0 same cycle, no Done; next Run with B=0 -> 0x0000 after 8 cycles.
- Run edge and ClearA_LoadB while Busy -> ignored, product unchanged; both in IDLE same cycle -> B loaded, no start.
- WIDTH=16: B=300, S=-5 -> {A,B}=0xFFFFFA24, X=1, latency 16+4=20.
